port_r_serializer_n: RTL and testbench
======================================

PORT_R_SERIALIZER_N -- requirements
Module: port_r_serializer_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one data word.
REQ-002 SHALL have parameter NUM_ENTRIES, default 3, number of parallel input entries; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port entry_data  input  NUM_ENTRIES*WIDTH  entry i word at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port entry_valid  input  NUM_ENTRIES  bit i qualifies entry i.
REQ-007 SHALL have port sout_ready  input  1  downstream accepts sout word this cycle.
REQ-008 SHALL have port sout_data  output  WIDTH  serialized word.
REQ-009 SHALL have port sout_valid  output  1  sout_data valid.
REQ-010 SHALL have port sout_index  output  clog2(NUM_ENTRIES), min 1  source entry index of sout_data.
REQ-011 SHALL have port sout_last  output  1  sout word is final word of its input group.
REQ-012 SHALL have port freeze_inputs  output  1  upstream holds entries; inputs ignored while high.

Function
REQ-013 SHALL implement FSM with states IDLE (pending mask zero) and DRAIN (pending mask nonzero); state register only, no other modes.
REQ-014 SHALL hold NUM_ENTRIES slot registers (data plus pending bit) and a registered group-index record.
REQ-015 freeze_inputs SHALL be 1 exactly when state is DRAIN; no combinational path from any input to freeze_inputs.
REQ-016 IDLE: sout_valid/sout_data/sout_index SHALL combinationally present lowest-index valid entry (zero latency); sout_valid=0 and sout_data=0 when no entry valid.
REQ-017 IDLE: on rising edge, every valid entry not consumed SHALL be loaded into its slot with pending=1; presented entry counts consumed only if sout_ready=1.
REQ-018 IDLE: if any pending bit set after load, next state SHALL be DRAIN; else remain IDLE.
REQ-019 DRAIN: sout SHALL present lowest-index pending slot, sout_valid=1; entry inputs ignored (not loaded, not passed).
REQ-020 DRAIN: on edge with sout_ready=1, pending bit of presented slot SHALL clear; sout_ready=0 leaves all slots and outputs unchanged.
REQ-021 DRAIN: when the last pending bit clears, next state SHALL be IDLE; first IDLE cycle accepts new inputs.
REQ-022 Output order within a group SHALL be strictly ascending entry index; no word lost, duplicated or reordered.
REQ-023 sout_last SHALL be 1 when sout_valid=1 and no other word of the group remains (IDLE: single valid entry; DRAIN: one pending bit).
REQ-024 Single valid entry with sout_ready=1 SHALL pass through in IDLE with no DRAIN cycle and freeze_inputs staying 0.
REQ-025 All entries valid with sout_ready held 1 SHALL emit NUM_ENTRIES words in NUM_ENTRIES consecutive cycles, freeze_inputs high for NUM_ENTRIES-1 cycles.
REQ-026 IDLE with sout_ready=0 and valid entries SHALL load all valid entries, including the presented one, and enter DRAIN.
REQ-027 Slot data of non-pending slots SHALL be held at 0.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, all slot data 0, all pending bits 0, group record 0.
REQ-029 While reset_n low, sout_valid, sout_last, freeze_inputs SHALL be 0 and sout_data, sout_index 0.
REQ-030 Reset asserted mid-DRAIN SHALL discard all pending words; first cycle after release behaves as IDLE.

Verification (WIDTH=8, NUM_ENTRIES=3)
REQ-031 valid=3'b111, data {0x33,0x22,0x11}, ready=1 -> cycle0 0x11 idx0, cycle1 0x22 idx1, cycle2 0x33 idx2 last=1; freeze 0,1,1,0.
REQ-032 valid=3'b100, data[2]=0xA5, ready=1 -> same cycle 0xA5 idx2 last=1; freeze stays 0; next cycle IDLE.
REQ-033 valid=3'b101, ready=0 for 2 cycles then 1 -> 0x11 held 3 cycles, then 0x33 last=1; freeze high until last accepted.
REQ-034 valid=3'b111 changed to new data during DRAIN -> new data ignored; original 0x22, 0x33 emitted.
REQ-035 reset_n pulsed low in cycle1 of REQ-031 -> sout_valid and freeze 0 immediately; 0x22/0x33 never emitted; next group accepted.
REQ-036 valid=3'b000 for several cycles -> sout_valid=0, freeze 0, state IDLE throughout.

Source files
------------

// File: rtl/port_r_serializer_n.sv
// port_r_serializer_n
//
// Turns a group of up to NUM_ENTRIES parallel words into a stream of single
// words on the sout port. The words of a group always come out in ascending
// entry-index order.
//
// IDLE  : the lowest-index valid entry is passed straight through with no
//         latency. On the clock edge, every valid entry that was not consumed
//         is captured into its slot. If any slot is captured, the block moves
//         to DRAIN.
// DRAIN : captured slots are emitted lowest index first. Entry inputs are
//         ignored and freeze_inputs asks upstream to hold. The block returns
//         to IDLE when the last slot is accepted.
//
// Handshake: a word transfers on a rising edge where sout_valid and
// sout_ready are both 1. sout_valid never depends on sout_ready. In DRAIN,
// when sout_ready is 0, the presented word and every slot stay unchanged.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   reset_n      : asynchronous active-low reset
//   entry_data   : NUM_ENTRIES*WIDTH; entry i is at [i*WIDTH +: WIDTH]
//   entry_valid  : NUM_ENTRIES; bit i qualifies entry i
//   sout_ready   : downstream accepts the sout word this cycle
//   sout_data    : serialized word
//   sout_valid   : sout_data is valid
//   sout_index   : source entry index of sout_data
//   sout_last    : sout word is the final word of its group
//   freeze_inputs: high while draining; upstream must hold its entries
//   fsm_state    : debug view of the state register (0 IDLE, 1 DRAIN)
module port_r_serializer_n #(
    parameter int WIDTH       = 8,
    parameter int NUM_ENTRIES = 3,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_ENTRIES*WIDTH-1:0] entry_data,
    input  logic [NUM_ENTRIES-1:0]       entry_valid,
    input  logic                         sout_ready,
    output logic [WIDTH-1:0]             sout_data,
    output logic                         sout_valid,
    output logic [IDX_W-1:0]             sout_index,
    output logic                         sout_last,
    output logic                         freeze_inputs,
    output logic [0:0]                   fsm_state
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]             state;
    logic [WIDTH-1:0]       slot_data [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] pending;
    // Index of the final word of the group in flight. In DRAIN, sout_last
    // means the presented slot is this one.
    logic [IDX_W-1:0]       group_last;

    logic [NUM_ENTRIES-1:0] src_mask;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [WIDTH-1:0]       sel_data;
    logic [NUM_ENTRIES-1:0] sel_onehot;
    logic [NUM_ENTRIES-1:0] load_mask;
    logic [IDX_W-1:0]       load_hi;
    logic                   last_word;

    always_comb begin
        src_mask   = (state == DRAIN) ? pending : entry_valid;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_data   = '0;
        sel_onehot = '0;
        // Scan downward so that the lowest set index is the one that remains.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                sel_found  = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_data   = (state == DRAIN) ? slot_data[i] : entry_data[i*WIDTH +: WIDTH];
                sel_onehot = NUM_ENTRIES'(1) << i;
            end
        end

        // In IDLE, the presented entry is consumed only when sout_ready is 1.
        load_mask = entry_valid & ~(sout_ready ? sel_onehot : '0);
        load_hi   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (load_mask[i]) load_hi = IDX_W'(i);
        end

        if (state == DRAIN) begin
            last_word = (sel_idx == group_last);
        end else begin
            last_word = ((entry_valid & (entry_valid - NUM_ENTRIES'(1))) == '0);
        end
    end

    // reset_n gates the outputs directly. While reset is held, IDLE
    // pass-through must not show the entry inputs.
    assign sout_valid    = reset_n & sel_found;
    assign sout_data     = sout_valid ? sel_data : '0;
    assign sout_index    = sout_valid ? sel_idx : '0;
    assign sout_last     = sout_valid & last_word;
    assign freeze_inputs = (state == DRAIN);
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            group_last <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) slot_data[i] <= '0;
        end else if (state == IDLE) begin
            pending <= load_mask;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slot_data[i] <= load_mask[i] ? entry_data[i*WIDTH +: WIDTH] : '0;
            end
            if (|load_mask) begin
                state      <= DRAIN;
                group_last <= load_hi;
            end
        end else if (sout_ready) begin
            pending <= pending & ~sel_onehot;
            // Slots that are not pending are kept at zero.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sel_onehot[i]) slot_data[i] <= '0;
            end
            if ((pending & ~sel_onehot) == '0) begin
                state      <= IDLE;
                group_last <= '0;
            end
        end
    end

endmodule

// File: tb/tb_port_r_serializer_n.sv
// Bench for port_r_serializer_n (WIDTH=8, NUM_ENTRIES=3).
// The reference model keeps the frozen group as a queue of {index, data}
// words. While the queue is empty, the lowest valid entry passes through.
module tb_port_r_serializer_n;

    localparam int W = 8;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] entry_data;
    logic [N-1:0]   entry_valid;
    logic           sout_ready;
    logic [W-1:0]   sout_data;
    logic           sout_valid;
    logic [1:0]     sout_index;
    logic           sout_last;
    logic           freeze_inputs;
    logic [0:0]     fsm_state;

    port_r_serializer_n #(.WIDTH(W), .NUM_ENTRIES(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .entry_data    (entry_data),
        .entry_valid   (entry_valid),
        .sout_ready    (sout_ready),
        .sout_data     (sout_data),
        .sout_valid    (sout_valid),
        .sout_index    (sout_index),
        .sout_last     (sout_last),
        .freeze_inputs (freeze_inputs),
        .fsm_state     (fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"},  32'(sout_valid), 0);
        check({tag, "_data"},   32'(sout_data), 0);
        check({tag, "_index"},  32'(sout_index), 0);
        check({tag, "_last"},   32'(sout_last), 0);
        check({tag, "_freeze"}, 32'(freeze_inputs), 0);
    endtask

    // One cycle: drive the inputs, check the outputs mid-cycle against the
    // model, take the clock edge, then advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        int          lo;
        logic        e_valid, e_last, e_freeze;
        logic [W-1:0] e_data;
        logic [1:0]  e_idx;
        entry_valid = v;
        entry_data  = d;
        sout_ready  = r;
        #2;
        lo = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) lo = i;
        if (q.size() == 0) begin
            e_valid  = (lo >= 0);
            e_data   = (lo >= 0) ? d[lo*W +: W] : '0;
            e_idx    = (lo >= 0) ? 2'(lo) : 2'd0;
            e_last   = ($countones(v) == 1);
            e_freeze = 1'b0;
        end else begin
            e_valid  = 1'b1;
            e_data   = q[0].data;
            e_idx    = q[0].idx;
            e_last   = (q.size() == 1);
            e_freeze = 1'b1;
        end
        check("valid",  32'(sout_valid), 32'(e_valid));
        check("data",   32'(sout_data), 32'(e_data));
        check("index",  32'(sout_index), 32'(e_idx));
        check("last",   32'(sout_last), 32'(e_last));
        check("freeze", 32'(freeze_inputs), 32'(e_freeze));
        check("state",  32'(fsm_state), 32'(e_freeze));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && !(r && i == lo)) q.push_back(item_t'{idx: 2'(i), data: d[i*W +: W]});
            end
        end else if (r) begin
            void'(q.pop_front());
        end
    endtask

    initial begin
        int guard;
        reset_n     = 1'b0;
        entry_valid = '0;
        entry_data  = '0;
        sout_ready  = 1'b0;
        #2;
        entry_valid = 3'b111;
        entry_data  = 24'h332211;
        #1;
        check_idle_zero("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // all entries valid, ready held high
        step(3'b111, 24'h332211, 1'b1);
        step(3'b111, 24'h332211, 1'b1);
        step(3'b111, 24'h332211, 1'b1);
        step(3'b000, 24'h000000, 1'b1);

        // single entry passes straight through
        step(3'b100, 24'hA50000, 1'b1);
        step(3'b000, 24'h000000, 1'b1);

        // stalled group: 0x11 held, then 0x33 last
        step(3'b101, 24'h332211, 1'b0);
        step(3'b101, 24'h332211, 1'b0);
        step(3'b101, 24'h332211, 1'b1);
        step(3'b101, 24'h332211, 1'b1);
        step(3'b000, 24'h000000, 1'b1);

        // inputs changed during DRAIN are ignored
        step(3'b111, 24'h332211, 1'b1);
        step(3'b111, 24'hCCBBAA, 1'b1);
        step(3'b111, 24'hCCBBAA, 1'b1);
        step(3'b000, 24'h000000, 1'b1);

        // idle with nothing valid
        for (int i = 0; i < 4; i++) step(3'b000, 24'h5A5A5A, 1'b1);

        // reset in the middle of a drain
        step(3'b111, 24'h332211, 1'b1);
        reset_n = 1'b0;
        #1;
        check_idle_zero("mid_drain_reset");
        q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(3'b011, 24'h004443, 1'b1);
        step(3'b011, 24'h004443, 1'b1);
        step(3'b000, 24'h000000, 1'b1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(N'($urandom_range(0, 7)), N*W'($urandom), ($urandom_range(0, 3) != 0));
        end

        // drain whatever is left
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step(3'b000, 24'h000000, 1'b1);
            guard++;
        end
        check("drain_bound", 32'(q.size()), 0);
        step(3'b000, 24'h000000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
